msr_spi_slave: RTL and testbench

Downstream readout stage for the timestamp capture block. On each rising edge of `data_rdy` it latches the 24-bit `msr_data` timestamp into a hold register. The Raspberry Pi then reads it over the GPIO pins with a mode-0 SPI frame: an 8-bit status header followed by the 24-bit timestamp, MSB first. All SPI inputs are asynchronous to `clk`; they are synchronised and edge-detected internally, so the block is fully synchronous to the PLL-generated 100 MHz `clk`.

---
 rtl/msr_spi_slave_pkg.sv | 27 ++
 rtl/msr_spi_slave_sync_edge.sv | 45 ++++
 rtl/msr_spi_slave.sv | 170 +++++++++++++++++
 tb/tb_msr_spi_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msr_spi_slave_pkg.sv
// Shared types and constants for the timestamp SPI readout block.
//   MSR_*_W      : frame field widths
//   state_t      : readout FSM state encoding
//   msr_frame_t  : 32-bit frame as seen on the wire, MSB first
package msr_pkg;

  localparam int unsigned MSR_DATA_W   = 24;
  localparam int unsigned MSR_STATUS_W = 8;
  localparam int unsigned MSR_FRAME_W  = 32;
  localparam int unsigned MSR_SEQ_W    = MSR_STATUS_W - 2;
  localparam int unsigned MSR_CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Status header followed by the held timestamp.
  typedef struct packed {
    logic                 valid;
    logic                 overrun;
    logic [MSR_SEQ_W-1:0] seq;
    logic [MSR_DATA_W-1:0] data;
  } msr_frame_t;

endpackage

// File: rtl/msr_spi_slave_sync_edge.sv
// Synchroniser plus registered edge detector for one asynchronous pin.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronised pin level
//   rise     : one-cycle pulse, coincident with level going high
//   fall     : one-cycle pulse, coincident with level going low
// Edges are suppressed until the chain has been refilled after reset, so a
// pin held low (or high) through reset never produces a spurious edge.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] primed;
  logic [STAGES:0]   taps;
  logic [STAGES:0]   primed_next;

  assign taps        = {chain, din};
  assign primed_next = {primed, 1'b1};
  assign level       = chain[STAGES-1];

  // taps[STAGES-1] is the level the last flop is about to take; comparing it
  // to the current level lets rise/fall be registered without extra latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= '0;
      primed <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      chain  <= taps[STAGES-1:0];
      primed <= primed_next[STAGES-1:0];
      rise   <= primed[STAGES-1] &  taps[STAGES-1] & ~taps[STAGES];
      fall   <= primed[STAGES-1] & ~taps[STAGES-1] &  taps[STAGES];
    end
  end

endmodule

// File: rtl/msr_spi_slave.sv
// Timestamp hold register read out by the Raspberry Pi as a mode-0 SPI frame.
//   clk, rst   : 100 MHz system clock, synchronous active-high reset
//   msr_data   : timestamp from the capture block
//   data_rdy   : capture-ready level; rising edge means new data
//   spi_cs_n   : Pi chip select (async, active low)
//   spi_sclk   : Pi SPI clock (async, CPOL=0/CPHA=0)
//   spi_miso   : serial data out, MSB first, driven 0 outside a frame
//   busy       : frame in progress
//   frame_done : one-cycle pulse when a full 32-bit frame has been read
//   overrun    : sticky, a capture landed on unread data
module msr_spi_slave
  import msr_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] msr_data,
  input  logic              data_rdy,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  output logic              spi_miso,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  state_t state, state_next;

  logic                   cs_level, cs_rise, cs_fall;
  logic                   sclk_level_unused, sclk_rise, sclk_fall;

  logic                   data_rdy_q;
  logic                   cap;
  logic [DATA_W-1:0]      hold;
  logic                   valid;
  logic [MSR_SEQ_W-1:0]   seq;
  logic                   cap_in_frame;
  logic                   ovr_in_frame;
  logic [MSR_FRAME_W-1:0] shreg;
  logic [MSR_CNT_W-1:0]   bitcnt;
  msr_frame_t             frame;

  logic load, shift, count, complete;

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign cap = data_rdy & ~data_rdy_q;

  // Frame snapshot taken at frame start.
  always_comb begin
    frame         = '0;
    frame.valid   = valid;
    frame.overrun = overrun;
    frame.seq     = seq;
    frame.data    = MSR_DATA_W'(hold);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    count      = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cs_n high again before the last bit: abandon the frame untouched.
        if (cs_level) begin
          state_next = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            count = 1'b1;
            if (bitcnt == MSR_CNT_W'(MSR_FRAME_W - 1)) state_next = ST_DONE;
          end
          if (sclk_fall && (bitcnt < MSR_CNT_W'(MSR_FRAME_W))) shift = 1'b1;
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture, hold, shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rdy_q   <= 1'b0;
      hold         <= '0;
      valid        <= 1'b0;
      overrun      <= 1'b0;
      seq          <= '0;
      cap_in_frame <= 1'b0;
      ovr_in_frame <= 1'b0;
      shreg        <= '0;
      bitcnt       <= '0;
      spi_miso     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      data_rdy_q <= data_rdy;
      frame_done <= complete;
      busy       <= (state_next == ST_SHIFT);
      spi_miso   <= (state == ST_SHIFT) ? shreg[MSR_FRAME_W-1] : 1'b0;

      if (load) begin
        shreg        <= frame;
        bitcnt       <= '0;
        cap_in_frame <= 1'b0;
        ovr_in_frame <= 1'b0;
      end else if (shift) begin
        shreg <= shreg << 1;
      end

      if (count) bitcnt <= bitcnt + MSR_CNT_W'(1);

      if (complete) begin
        seq     <= seq + MSR_SEQ_W'(1);
        valid   <= cap_in_frame;
        overrun <= ovr_in_frame;
      end

      // Placed after completion so a coincident capture wins.
      if (cap) begin
        hold  <= msr_data;
        valid <= 1'b1;
        if (valid) overrun <= 1'b1;
        // A capture on the load cycle is not in the snapshot either.
        if ((state != ST_IDLE) || load) begin
          cap_in_frame <= 1'b1;
          if (valid) ovr_in_frame <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_msr_spi_slave.sv
module tb_msr_spi_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] msr_data;
  logic        data_rdy;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_miso;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model of the readout state.
  logic        m_valid, m_ovr, m_cif, m_oif, in_frame;
  logic [5:0]  m_seq;
  logic [23:0] m_hold;
  logic [31:0] exp_q[$];

  msr_spi_slave #(.DATA_W(24), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .msr_data   (msr_data),
    .data_rdy   (data_rdy),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_miso   (spi_miso),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #9000000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic m_clear();
    m_valid = 0; m_ovr = 0; m_cif = 0; m_oif = 0; in_frame = 0;
    m_seq = '0; m_hold = '0;
    exp_q.delete();
  endtask

  task automatic m_capture(input logic [23:0] d);
    if (m_valid) m_ovr = 1;
    if (in_frame) begin
      m_cif = 1;
      if (m_valid) m_oif = 1;
    end
    m_valid = 1;
    m_hold  = d;
  endtask

  task automatic m_start();
    exp_q.push_back({m_valid, m_ovr, m_seq, m_hold});
    m_cif = 0; m_oif = 0; in_frame = 1;
  endtask

  task automatic m_complete();
    m_seq   = m_seq + 6'd1;
    m_valid = m_cif;
    m_ovr   = m_oif;
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxxxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; spi_cs_n = 1; spi_sclk = 0; data_rdy = 0; msr_data = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    m_clear();
    repeat (6) @(negedge clk);
  endtask

  task automatic capture(input logic [23:0] d);
    @(negedge clk);
    msr_data = d; data_rdy = 1;
    m_capture(d);
    repeat (3) @(negedge clk);
    data_rdy = 0;
    repeat (3) @(negedge clk);
  endtask

  // Pi-side read: samples MISO just before each rising SCLK.
  task automatic spi_frame(input int nbits, input int half, input int cap_bit,
                           input logic [23:0] cap_data, input bit keep_cs,
                           output logic [31:0] got, output int fd_cnt, output int fd_at,
                           output logic miso3, output logic miso4, output logic busy_mid);
    got = '0; fd_cnt = 0; fd_at = -1;
    @(negedge clk);
    spi_cs_n = 0;
    m_start();
    repeat (3) @(negedge clk);
    miso3 = spi_miso;
    @(negedge clk);
    miso4 = spi_miso; busy_mid = busy;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      if (b == cap_bit) capture(cap_data);
      got[31-b] = spi_miso;
      spi_sclk = 1;
      repeat (half) @(negedge clk);
      spi_sclk = 0;
      repeat (half) @(negedge clk);
    end
    if (!keep_cs) begin
      spi_cs_n = 1;
      in_frame = 0;
      if (nbits == 32) m_complete();
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (frame_done === 1'b1) begin
          fd_cnt++;
          if (fd_at < 0) fd_at = i;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (spi_miso !== 1'b0)   begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_basic_read();
    logic [31:0] got, exp;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    capture(24'h123456);
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp)        begin failures++; $display("FAIL basic_frame got=%h exp=%h", got, exp); end
    checks++; if (got !== 32'h80123456) begin failures++; $display("FAIL basic_literal got=%h exp=80123456", got); end
    checks++; if (m3 !== 1'b0)        begin failures++; $display("FAIL basic_miso_cyc3 got=%b exp=0", m3); end
    checks++; if (m4 !== 1'b1)        begin failures++; $display("FAIL basic_miso_cyc4 got=%b exp=1", m4); end
    checks++; if (bm !== 1'b1)        begin failures++; $display("FAIL basic_busy_mid got=%b exp=1", bm); end
    checks++; if (fc != 1)            begin failures++; $display("FAIL basic_done_count got=%0d exp=1", fc); end
    checks++; if (fa != 3)            begin failures++; $display("FAIL basic_done_latency got=%0d exp=3", fa); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp)        begin failures++; $display("FAIL basic_reread got=%h exp=%h", got, exp); end
  endtask

  task automatic test_empty_read();
    logic [31:0] got, exp;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL empty_first got=%h exp=%h", got, exp); end
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL empty_second got=%h exp=%h", got, exp); end
    checks++; if (got !== 32'h01000000) begin failures++; $display("FAIL empty_literal got=%h exp=01000000", got); end
  endtask

  task automatic test_overrun();
    logic [31:0] got, exp;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    capture(24'h000010);
    capture(24'h000020);
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ovr_set got=%b exp=%b", overrun, m_ovr); end
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL ovr_frame got=%h exp=%h", got, exp); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ovr_cleared got=%b exp=%b", overrun, m_ovr); end
    capture(24'h000030);
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL ovr_next got=%h exp=%h", got, exp); end
  endtask

  task automatic test_abort();
    logic [31:0] got, exp, mask;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    capture(24'h00ABC1);
    spi_frame(12, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    mask = 32'hFFFFFFFF;
    mask = ~(mask >> 12);
    checks++; if ((got & mask) !== (exp & mask)) begin failures++; $display("FAIL abort_bits got=%h exp=%h", got & mask, exp & mask); end
    checks++; if (fc != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", fc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL abort_resend got=%h exp=%h", got, exp); end
  endtask

  task automatic test_capture_during_frame();
    logic [31:0] got, exp;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    capture(24'h111111);
    spi_frame(32, 10, 16, 24'hABCDEF, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL capf_frame got=%h exp=%h", got, exp); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL capf_overrun got=%b exp=%b", overrun, m_ovr); end
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL capf_next got=%h exp=%h", got, exp); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL capf_ovr_after got=%b exp=%b", overrun, m_ovr); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] got, exp, mask;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    capture(24'h555555);
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL rmf_pre got=%h exp=%h", got, exp); end
    spi_frame(20, 10, -1, '0, 1, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    mask = 32'hFFFFFFFF;
    mask = ~(mask >> 20);
    checks++; if ((got & mask) !== (exp & mask)) begin failures++; $display("FAIL rmf_partial got=%h exp=%h", got & mask, exp & mask); end
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    m_clear();
    repeat (2) @(negedge clk);
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL rmf_miso got=%b exp=0", spi_miso); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmf_busy got=%b exp=0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmf_no_restart got=%b exp=0", busy); end
    spi_cs_n = 1;
    repeat (10) @(negedge clk);
    spi_frame(32, 10, -1, '0, 0, got, fc, fa, m3, m4, bm);
    exp = pop_exp();
    checks++; if (got !== exp) begin failures++; $display("FAIL rmf_fresh got=%h exp=%h", got, exp); end
    checks++; if (fc != 1)     begin failures++; $display("FAIL rmf_done got=%0d exp=1", fc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    int fc, fa;
    logic m3, m4, bm;
    do_reset();
    for (int f = 0; f <= 64; f++) begin
      if (f == 5) capture(24'h0F0F0F);
      spi_frame(32, 4, -1, '0, 0, got, fc, fa, m3, m4, bm);
      exp = pop_exp();
      checks++; if (got !== exp) begin failures++; $display("FAIL b2b_frame%0d got=%h exp=%h", f, got, exp); end
      if (f == 63) begin
        checks++; if (got !== 32'h3F0F0F0F) begin failures++; $display("FAIL b2b_seq63 got=%h exp=3f0f0f0f", got); end
      end
      if (f == 64) begin
        checks++; if (got !== 32'h000F0F0F) begin failures++; $display("FAIL b2b_wrap got=%h exp=000f0f0f", got); end
      end
    end
  endtask

  initial begin
    rst = 1; spi_cs_n = 1; spi_sclk = 0; data_rdy = 0; msr_data = '0;
    m_clear();
    test_reset();
    test_basic_read();
    test_empty_read();
    test_overrun();
    test_abort();
    test_capture_during_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
